scan_decoder: RTL and testbench

Parametrised, registered N-to-2^N decoder with active-low outputs and an enable, plus an auto-scan mode that cycles through outputs at a programmable rate. It is the next generation of the team's 2-to-4 decoder: wider select, a clocked output stage, and a built-in sequencer for time-multiplexed loads such as 7-segment digit strobes and keypad column drives. It sits between the control logic and the board-level strobe pins.

---
 rtl/scan_decoder.sv | 106 ++++++++++
 tb/tb_scan_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2^N decoder with active-low outputs, an
// active-low enable and an auto-scan sequencer for time-multiplexed strobes.
//
// MODE=0 decodes SEL directly (one cycle of latency). MODE=1 steps the index
// every DIV cycles and wraps from 2^SEL_W-1 to 0, pulsing WRAP for the cycle
// that follows the wrap.
//
// Optional feature macro: SCAN_DECODER_BLANK_EN
//   Defined   - in scan mode, each step is followed by one all-ones blank cycle
//               on Y_L (break-before-make). CUR already shows the new index
//               during that cycle. Needs DIV >= 2.
//   Undefined - Y_L switches straight from the old one-hot to the new one.
module scan_decoder #(
  parameter int SEL_W = 2,
  parameter int DIV   = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    G_L,
  input  logic                    MODE,
  input  logic [SEL_W-1:0]        SEL,
  output logic [(2**SEL_W)-1:0]   Y_L,
  output logic [SEL_W-1:0]        CUR,
  output logic                    WRAP
);

  localparam int N  = 2 ** SEL_W;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
  localparam logic [SEL_W-1:0] IDX_MAX   = SEL_W'(N - 1);

`ifdef SCAN_DECODER_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  // Parameter legality is checked at elaboration so a bad build never slips
  // through to silicon.
  generate
    if (SEL_W < 1 || SEL_W > 5) begin : g_bad_sel_w
      $error("scan_decoder: SEL_W must be in 1..5");
    end
    if (DIV < 1 || DIV > 65535) begin : g_bad_div
      $error("scan_decoder: DIV must be in 1..65535");
    end
    if (BLANK_EN && DIV < 2) begin : g_bad_blank_div
      $error("scan_decoder: blanking needs DIV >= 2");
    end
  endgenerate

  logic [SEL_W-1:0] index_q, index_n;
  logic [PW-1:0]    presc_q, presc_n;
  logic             wrap_n;
  logic             blank_n;
  logic [N-1:0]     y_n;

  // Next-state: direct load, prescaler count, or a scan step. MODE=0 takes
  // priority over a pending step so a falling MODE always loads SEL.
  always_comb begin
    index_n = index_q;
    presc_n = presc_q;
    wrap_n  = 1'b0;
    blank_n = 1'b0;
    if (!MODE) begin
      index_n = SEL;
      presc_n = '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_n = '0;
      index_n = index_q + 1'b1;
      wrap_n  = (index_q == IDX_MAX);
      blank_n = BLANK_EN;
    end else begin
      presc_n = presc_q + 1'b1;
    end
  end

  // Output decode from the next index so Y_L, CUR and WRAP update together.
  // G_L only gates the pins; the sequencer keeps running underneath it.
  always_comb begin
    y_n = '1;
    for (int i = 0; i < N; i++) begin
      if (!G_L && !blank_n && (index_n == SEL_W'(i))) begin
        y_n[i] = 1'b0;
      end
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      index_q <= '0;
      presc_q <= '0;
      Y_L     <= '1;
      WRAP    <= 1'b0;
    end else begin
      index_q <= index_n;
      presc_q <= presc_n;
      Y_L     <= y_n;
      WRAP    <= wrap_n;
    end
  end

  assign CUR = index_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: two decoder instances (SEL_W=2/DIV=4 and SEL_W=3/DIV=3)
// share control inputs. A behavioural model tracks index and dwell count per
// instance and is compared on every cycle; directed steps add literal checks.
module tb_scan_decoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, g_l, mode;
  logic [1:0] sel_a;
  logic [2:0] sel_b;
  logic [3:0] y_a;
  logic [1:0] cur_a;
  logic       wrap_a;
  logic [7:0] y_b;
  logic [2:0] cur_b;
  logic       wrap_b;

  int total = 0;
  int bad   = 0;

`ifdef SCAN_DECODER_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  scan_decoder #(.SEL_W(2), .DIV(4)) dut_a (
    .CLK(clk), .RST(rst), .G_L(g_l), .MODE(mode), .SEL(sel_a),
    .Y_L(y_a), .CUR(cur_a), .WRAP(wrap_a)
  );

  scan_decoder #(.SEL_W(3), .DIV(3)) dut_b (
    .CLK(clk), .RST(rst), .G_L(g_l), .MODE(mode), .SEL(sel_b),
    .Y_L(y_b), .CUR(cur_b), .WRAP(wrap_b)
  );

  // ---------------- scoreboard helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int idx;
    int cnt;   // cycles already spent on idx while scanning
    bit wrap;
    bit on;    // one-hot visible on the pins
  } mstate_t;

  function automatic mstate_t model_next(mstate_t s, bit r, bit g, bit m,
                                         int sel, int w, int div);
    mstate_t n;
    n      = s;
    n.wrap = 1'b0;
    n.on   = !g;
    if (r) begin
      n.idx = 0;
      n.cnt = 0;
      n.on  = 1'b0;
    end else if (!m) begin
      n.idx = sel;
      n.cnt = 0;
    end else begin
      n.cnt = s.cnt + 1;
      if (n.cnt == div) begin
        n.cnt  = 0;
        n.idx  = (s.idx + 1) % (1 << w);
        n.wrap = (n.idx == 0);
        if (BLANK) n.on = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic int model_y(mstate_t s, int w);
    int all_ones;
    all_ones = (1 << (1 << w)) - 1;
    return s.on ? (all_ones ^ (1 << s.idx)) : all_ones;
  endfunction

  mstate_t ma = '{0, 0, 1'b0, 1'b0};
  mstate_t mb = '{0, 0, 1'b0, 1'b0};
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    ma = model_next(ma, rst, g_l, mode, int'(sel_a), 2, 4);
    mb = model_next(mb, rst, g_l, mode, int'(sel_b), 3, 3);
    if (rst) m_valid = 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_y_a",    y_a,    model_y(ma, 2));
      chk("model_cur_a",  cur_a,  ma.idx);
      chk("model_wrap_a", wrap_a, ma.wrap);
      chk("model_y_b",    y_b,    model_y(mb, 3));
      chk("model_cur_b",  cur_b,  mb.idx);
      chk("model_wrap_b", wrap_b, mb.wrap);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset with MODE=1 so scanning starts from 0 on release.
  task automatic reset_into_scan();
    rst  = 1'b1;
    mode = 1'b1;
    g_l  = 1'b0;
    cyc(1);
    chk("rst_y_a",    y_a,    4'hF);
    chk("rst_cur_a",  cur_a,  2'd0);
    chk("rst_wrap_a", wrap_a, 1'b0);
    chk("rst_y_b",    y_b,    8'hFF);
    chk("rst_cur_b",  cur_b,  3'd0);
    rst = 1'b0;
  endtask

  // k cycles after a point where both instances show sa/sb with a fresh
  // dwell: index = start + k/DIV, wrap when a step lands on 0.
  task automatic run_scan(input int sa, input int sb, input int n);
    int ca, cb;
    bit step_a, step_b;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      ca = (sa + k / 4) % 4;
      cb = (sb + k / 3) % 8;
      step_a = (k % 4 == 0);
      step_b = (k % 3 == 0);
      chk("scan_cur_a",  cur_a,  ca);
      chk("scan_wrap_a", wrap_a, step_a && ca == 0);
      chk("scan_y_a",    y_a,    (BLANK && step_a) ? 4'hF : (4'hF ^ (4'h1 << ca)));
      chk("scan_cur_b",  cur_b,  cb);
      chk("scan_wrap_b", wrap_b, step_b && cb == 0);
      chk("scan_y_b",    y_b,    (BLANK && step_b) ? 8'hFF : (8'hFF ^ (8'h01 << cb)));
    end
  endtask

  // ---------------- directed stimulus ----------------
  logic [3:0] sweep_tbl [4];

  initial begin
    sweep_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst   = 1'b1;
    g_l   = 1'b1;
    mode  = 1'b0;
    sel_a = 2'd0;
    sel_b = 3'd0;

    // Reset held two cycles.
    cyc(2);
    chk("reset_y_a",    y_a,    4'b1111);
    chk("reset_cur_a",  cur_a,  2'd0);
    chk("reset_wrap_a", wrap_a, 1'b0);

    // Direct decode with one cycle latency.
    rst   = 1'b0;
    g_l   = 1'b0;
    sel_a = 2'd2;
    sel_b = 3'd6;
    cyc(1);
    chk("direct_y_a",   y_a,   4'b1011);
    chk("direct_cur_a", cur_a, 2'd2);
    chk("direct_y_b",   y_b,   8'hBF);

    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s);
      cyc(1);
      chk("sweep_y_a", y_a, sweep_tbl[s]);
    end

    // Enable gating.
    sel_a = 2'd3;
    cyc(1);
    chk("gate_on_y_a", y_a, 4'b0111);
    g_l = 1'b1;
    cyc(1);
    chk("gate_off_y_a",   y_a,   4'b1111);
    chk("gate_off_cur_a", cur_a, 2'd3);
    g_l = 1'b0;
    cyc(1);
    chk("gate_back_y_a", y_a, 4'b0111);

    // Scan from reset, with two wraps on instance a.
    reset_into_scan();
    run_scan(0, 0, 41);   // ends at CUR_a=2 with one cycle of dwell spent

    // Mid-scan reset, then a full dwell on index 0.
    reset_into_scan();
    run_scan(0, 0, 20);

    // Mode switch 0->1 starts scanning from the loaded SEL.
    mode  = 1'b0;
    sel_a = 2'd1;
    sel_b = 3'd5;
    cyc(1);
    chk("load_cur_a", cur_a, 2'd1);
    mode = 1'b1;
    run_scan(1, 5, 9);

    // MODE falls on a cycle where a would wrap 3->0: load wins, no WRAP.
    mode  = 1'b0;
    sel_a = 2'd3;
    sel_b = 3'd7;
    cyc(1);
    mode = 1'b1;
    run_scan(3, 7, 3);
    mode  = 1'b0;
    sel_a = 2'd0;
    sel_b = 3'd0;
    cyc(1);
    chk("drop_cur_a",  cur_a,  2'd0);
    chk("drop_wrap_a", wrap_a, 1'b0);
    chk("drop_y_a",    y_a,    4'b1110);
    chk("drop_wrap_b", wrap_b, 1'b0);

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
